alu_issue_ctrl: RTL

- Multi-cycle execute-stage sequencer that issues one operation at a time to the combinational ALU, then returns its registered result.
- Upstream: accepts decoded requests from the decode stage over a valid/ready handshake.
- ALU side: registers operands, operation code and ALUSrc onto the ALU input ports and captures the ALU result and Zero flag one cycle later.
- Downstream: presents the captured result, Zero, a BEQ-style branch-taken flag and a destination tag to writeback over a valid/ready handshake; also keeps a retired-operation counter.

---
 rtl/alu_issue_ctrl_if.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between decode, the ALU issue sequencer
// and writeback.
//   master : decode/writeback side (drives req_*, rsp_ready)
//   slave  : sequencer side (drives req_ready, rsp_*)
interface alu_issue_ctrl_if #(
  parameter int unsigned TAG_W = 5
);
  // Upstream request channel
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [31:0]       req_rs1;
  logic [31:0]       req_rs2;
  logic [31:0]       req_imm;
  logic              req_alusrc;
  logic              req_is_branch;
  logic [TAG_W-1:0]  req_tag;

  // Downstream response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
  logic              rsp_branch_taken;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_illegal;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_imm, req_alusrc,
           req_is_branch, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_branch_taken,
           rsp_tag, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_imm, req_alusrc,
           req_is_branch, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_branch_taken,
           rsp_tag, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts one decoded request, registers it onto the
// external combinational ALU, captures the ALU result one cycle later and
// holds it for writeback until the response handshake completes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       req_* request handshake in, rsp_* response handshake out
//   alu_data1/2, alu_branch_add, alu_operation, alu_alusrc  registered to ALU
//   alu_result, alu_zero                                    from ALU
//   ops_retired       count of completed response handshakes (wraps)
// Build option: ALU_ISSUE_OPCHECK_EN -- unsupported op codes are not issued
// and produce a response with rsp_illegal=1 and zeroed data.
module alu_issue_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [31:0]       alu_data1,
  output logic [31:0]       alu_data2,
  output logic [31:0]       alu_branch_add,
  output logic [3:0]        alu_operation,
  output logic              alu_alusrc,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic [CNT_W-1:0]  ops_retired
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_c, load_c, capture_c, retire_c, op_ok_c;

  logic [31:0]       alu_data1_q, alu_data2_q, alu_branch_add_q;
  logic [3:0]        alu_operation_q;
  logic              alu_alusrc_q;
  logic              is_branch_q, illegal_q;
  logic [TAG_W-1:0]  tag_q;

  logic [31:0]       rsp_result_q;
  logic              rsp_zero_q, rsp_branch_taken_q, rsp_illegal_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic [CNT_W-1:0]  ops_retired_q;

`ifdef ALU_ISSUE_OPCHECK_EN
  // AND, OR, ADD, SUB, SLT
  function automatic logic op_supported(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
           (op == 4'b0110) || (op == 4'b0111);
  endfunction
  assign op_ok_c = op_supported(bus.req_op);
`else
  assign op_ok_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Next-state and handshake decode; req_ready is combinational from rsp_ready
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = 1'b0;
    capture_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = EXEC;
      end
      EXEC: begin
        capture_c   = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        req_ready_c = bus.rsp_ready;
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = bus.req_valid ? EXEC : IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    load_c   = bus.req_valid & req_ready_c;
    retire_c = rsp_valid_q & bus.rsp_ready;
  end

  // ALU port and request-side registers: change only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_data1_q      <= '0;
      alu_data2_q      <= '0;
      alu_branch_add_q <= '0;
      alu_operation_q  <= '0;
      alu_alusrc_q     <= 1'b0;
      is_branch_q      <= 1'b0;
      illegal_q        <= 1'b0;
      tag_q            <= '0;
    end else if (load_c) begin
      alu_data1_q      <= bus.req_rs1;
      alu_data2_q      <= bus.req_rs2;
      alu_branch_add_q <= bus.req_imm;
      alu_alusrc_q     <= bus.req_alusrc;
      is_branch_q      <= bus.req_is_branch;
      illegal_q        <= ~op_ok_c;
      tag_q            <= bus.req_tag;
      // A rejected op code leaves the ALU running the previous operation
      if (op_ok_c) alu_operation_q <= bus.req_op;
    end
  end

  // Response registers: captured at the end of EXEC, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q       <= '0;
      rsp_zero_q         <= 1'b0;
      rsp_branch_taken_q <= 1'b0;
      rsp_illegal_q      <= 1'b0;
      rsp_tag_q          <= '0;
    end else if (capture_c) begin
      rsp_result_q       <= illegal_q ? 32'd0 : alu_result;
      rsp_zero_q         <= ~illegal_q & alu_zero;
      rsp_branch_taken_q <= ~illegal_q & is_branch_q & alu_zero;
      rsp_illegal_q      <= illegal_q;
      rsp_tag_q          <= tag_q;
    end
  end

  // Retired-operation counter, wraps modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ops_retired_q <= '0;
    else if (retire_c) ops_retired_q <= ops_retired_q + CNT_W'(1);
  end

  assign bus.req_ready        = req_ready_c;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_result       = rsp_result_q;
  assign bus.rsp_zero         = rsp_zero_q;
  assign bus.rsp_branch_taken = rsp_branch_taken_q;
  assign bus.rsp_tag          = rsp_tag_q;
  assign bus.rsp_illegal      = rsp_illegal_q;

  assign alu_data1      = alu_data1_q;
  assign alu_data2      = alu_data2_q;
  assign alu_branch_add = alu_branch_add_q;
  assign alu_operation  = alu_operation_q;
  assign alu_alusrc     = alu_alusrc_q;
  assign ops_retired    = ops_retired_q;

endmodule
